// File: rtl/sa_result_display.sv
// Captures the solver result on each rising edge of done, converts it to BCD
// with a serial double-dabble, and scans the value onto a 3-digit common-anode display.
module sa_result_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [7:0]  x,
    output logic        busy,
    output logic        valid,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    // Handshake: x is taken on the cycle done rises (no ready, nothing is refused:
    // a result arriving while busy waits in a one-deep buffer, latest wins);
    // valid pulses for one cycle on the same edge bcd takes its new value.

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        done_d;
    logic        armed;
    logic        event_w;
    logic [19:0] sh, sh_nxt, adj;
    logic [2:0]  iter, iter_nxt;
    logic [7:0]  pend_x;
    logic        pending;
    logic        pend_take;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    dig;
    logic [2:0]    an_w;
    logic [6:0]    seg_w;
    logic [3:0]    nib;
    logic          blank;

    // armed masks the first edge after reset so a done held high across
    // release is not mistaken for a fresh rising edge.
    assign event_w = done & ~done_d & armed;
    assign busy    = (state != S_IDLE);

    always_comb begin
        adj = sh;
        if (sh[19:16] >= 4'd5) adj[19:16] = sh[19:16] + 4'd3;
        if (sh[15:12] >= 4'd5) adj[15:12] = sh[15:12] + 4'd3;
        if (sh[11:8]  >= 4'd5) adj[11:8]  = sh[11:8]  + 4'd3;
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        iter_nxt  = iter;
        pend_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (event_w) begin
                    sh_nxt    = {12'b0, x};
                    iter_nxt  = 3'd0;
                    state_nxt = S_CONV;
                    pend_take = 1'b1;
                end else if (pending) begin
                    sh_nxt    = {12'b0, pend_x};
                    iter_nxt  = 3'd0;
                    state_nxt = S_CONV;
                    pend_take = 1'b1;
                end
            end
            S_CONV: begin
                sh_nxt   = {adj[18:0], 1'b0};
                iter_nxt = iter + 3'd1;
                if (iter == 3'd7) state_nxt = S_FIN;
            end
            S_FIN: begin
                if (pending) begin
                    sh_nxt    = {12'b0, pend_x};
                    iter_nxt  = 3'd0;
                    state_nxt = S_CONV;
                    pend_take = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh      <= 20'd0;
            iter    <= 3'd0;
            done_d  <= 1'b0;
            armed   <= 1'b0;
            valid   <= 1'b0;
            bcd     <= 12'h000;
            pend_x  <= 8'd0;
            pending <= 1'b0;
        end else begin
            state  <= state_nxt;
            sh     <= sh_nxt;
            iter   <= iter_nxt;
            done_d <= done;
            armed  <= 1'b1;
            valid  <= (state == S_FIN);
            if (state == S_FIN) bcd <= sh[19:8];
            // A new event while busy always lands in the buffer, even on the
            // cycle the buffer is being drained into the converter.
            if (event_w && state != S_IDLE) begin
                pend_x  <= x;
                pending <= 1'b1;
            end else if (pend_take) begin
                pending <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        an_w  = 3'b110;
        nib   = bcd[3:0];
        blank = 1'b0;
        case (dig)
            2'd1: begin
                an_w  = 3'b101;
                nib   = bcd[7:4];
                blank = BLANK_LZ && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                an_w  = 3'b011;
                nib   = bcd[11:8];
                blank = BLANK_LZ && (bcd[11:8] == 4'd0);
            end
            default: begin
                an_w  = 3'b110;
                nib   = bcd[3:0];
                blank = 1'b0;
            end
        endcase
        seg_w = blank ? 7'b1111111 : seg_decode(nib);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig      <= 2'd0;
            an       <= 3'b110;
            seg      <= 7'b1000000;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig      <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= an_w;
            seg <= seg_w;
        end
    end

endmodule

// File: tb/tb_sa_result_display.sv
// Bench for sa_result_display: table vectors, hand-written timing sequences and
// a swept/random stream scored against an arithmetic decimal-digit model.
module tb_sa_result_display;

    logic        clk;
    logic        rst_n;
    logic        done;
    logic [7:0]  x;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    sa_result_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .x(x),
        .busy(busy), .valid(valid), .bcd(bcd), .an(an), .seg(seg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] bcd_model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns one sample after the edge that sees the rising edge of done
    task automatic pulse_done(input logic [7:0] v);
        x    = v;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!valid) check({name, "_timeout"}, 32'(valid), 32'd1);
    endtask

    task automatic scan_check(input string name, input logic [6:0] eh,
                              input logic [6:0] et, input logic [6:0] eo);
        int n_o, n_t, n_h, n_bad, n_seg, n_tr;
        logic [2:0] prev;
        n_o = 0; n_t = 0; n_h = 0; n_bad = 0; n_seg = 0; n_tr = 0;
        prev = an;
        for (int i = 0; i < 12; i++) begin
            case (an)
                3'b110: begin n_o++; if (seg !== eo) n_seg++; end
                3'b101: begin n_t++; if (seg !== et) n_seg++; end
                3'b011: begin n_h++; if (seg !== eh) n_seg++; end
                default: n_bad++;
            endcase
            if (i > 0 && an !== prev) begin
                n_tr++;
                if (!((prev == 3'b110 && an == 3'b101) || (prev == 3'b101 && an == 3'b011) ||
                      (prev == 3'b011 && an == 3'b110)))
                    n_bad++;
            end
            prev = an;
            tick();
        end
        check({name, "_ones_hold"}, n_o, 4);
        check({name, "_tens_hold"}, n_t, 4);
        check({name, "_hund_hold"}, n_h, 4);
        check({name, "_seg_errs"}, n_seg, 0);
        check({name, "_an_order"}, n_bad, 0);
        check({name, "_few_switches"}, 32'(n_tr <= 3), 1);
    endtask

    // scoreboard: every valid pulse consumes the oldest expected result
    always begin
        @(posedge clk);
        #1;
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got bcd %0h required no valid", bcd);
            end else begin
                check("sb_bcd", 32'(bcd), 32'(exp_q.pop_front()));
            end
            check("sb_nibbles_le9", 32'((bcd[11:8] <= 9) && (bcd[7:4] <= 9) && (bcd[3:0] <= 9)), 1);
        end
    end

    typedef struct {
        logic [7:0]  x;
        logic [11:0] bcd;
        logic [6:0]  seg_h;
        logic [6:0]  seg_t;
        logic [6:0]  seg_o;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, bcnt, vcnt, v1, v2, bad;

        vecs[0] = '{8'd7,   12'h007, 7'b1111111, 7'b1111111, 7'b1111000};
        vecs[1] = '{8'd255, 12'h255, 7'b0100100, 7'b0010010, 7'b0010010};
        vecs[2] = '{8'd0,   12'h000, 7'b1111111, 7'b1111111, 7'b1000000};
        vecs[3] = '{8'd42,  12'h042, 7'b1111111, 7'b0011001, 7'b0100100};
        vecs[4] = '{8'd105, 12'h105, 7'b1111001, 7'b1000000, 7'b0010010};
        vecs[5] = '{8'd200, 12'h200, 7'b0100100, 7'b1000000, 7'b1000000};

        rst_n = 1'b0;
        done  = 1'b0;
        x     = 8'd0;
        repeat (3) tick();
        check("rst_busy",  32'(busy),  0);
        check("rst_valid", 32'(valid), 0);
        check("rst_bcd",   32'(bcd),   32'h000);
        check("rst_an",    32'(an),    32'b110);
        check("rst_seg",   32'(seg),   32'b1000000);
        rst_n = 1'b1;
        repeat (3) tick();

        // single conversion: busy width and latency
        pulse_done(8'd200);
        exp_q.push_back(bcd_model(200));
        bcnt = 0; vcnt = 0; v1 = -1;
        for (int k = 0; k < 16; k++) begin
            if (busy) bcnt++;
            if (valid) begin vcnt++; v1 = k; end
            tick();
        end
        check("t1_busy_cycles", bcnt, 9);
        check("t1_valid_count", vcnt, 1);
        check("t1_latency", v1, 9);
        check("t1_bcd", 32'(bcd), 32'h200);

        // table vectors with display scan
        for (int i = 0; i < 6; i++) begin
            pulse_done(vecs[i].x);
            exp_q.push_back(bcd_model(int'(vecs[i].x)));
            wait_valid("tbl", lat);
            check("tbl_latency", lat, 9);
            check("tbl_bcd", 32'(bcd), 32'(vecs[i].bcd));
            repeat (2) tick();
            scan_check("tbl_scan", vecs[i].seg_h, vecs[i].seg_t, vecs[i].seg_o);
        end

        // pending buffer: 100, then 42 three cycles later, then 99 five later
        repeat (3) tick();
        pulse_done(8'd100);
        exp_q.push_back(bcd_model(100));
        exp_q.push_back(bcd_model(99));
        repeat (2) tick();
        pulse_done(8'd42);
        repeat (4) tick();
        pulse_done(8'd99);
        v1 = -1; v2 = -1; vcnt = 0; bad = 0;
        for (int k = 8; k < 26; k++) begin
            if (valid) begin
                vcnt++;
                if (v1 < 0) begin
                    v1 = k;
                    check("pend_first_bcd", 32'(bcd), 32'h100);
                end else begin
                    v2 = k;
                    check("pend_second_bcd", 32'(bcd), 32'h099);
                end
            end
            if (k < 18 && !busy) bad++;
            tick();
        end
        check("pend_valid_count", vcnt, 2);
        check("pend_first_at", v1, 9);
        check("pend_gap", v2 - v1, 9);
        check("pend_busy_gapless", bad, 0);

        // reset mid-conversion, done held high through release
        repeat (3) tick();
        pulse_done(8'd150);
        repeat (3) tick();
        rst_n = 1'b0;
        done  = 1'b1;
        tick();
        exp_q.delete();
        check("midrst_busy",  32'(busy),  0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_bcd",   32'(bcd),   32'h000);
        check("midrst_an",    32'(an),    32'b110);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy || valid) bad++;
        end
        check("held_done_no_conv", bad, 0);
        done = 1'b0;
        repeat (2) tick();
        pulse_done(8'd150);
        exp_q.push_back(bcd_model(150));
        wait_valid("after_rst", lat);
        check("after_rst_bcd", 32'(bcd), 32'h150);
        repeat (3) tick();

        // sweep every x, then random x, with randomized spacing of >= 9 cycles
        for (int v = 0; v < 256; v++) begin
            pulse_done(8'(v));
            exp_q.push_back(bcd_model(v));
            repeat (8 + $urandom_range(0, 4)) tick();
        end
        for (int n = 0; n < 40; n++) begin
            int rv;
            rv = int'($urandom_range(0, 255));
            pulse_done(8'(rv));
            exp_q.push_back(bcd_model(rv));
            repeat (8 + $urandom_range(0, 6)) tick();
        end
        lat = 0;
        while (exp_q.size() > 0 && lat < 100) begin
            tick();
            lat++;
        end
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
